// File: rtl/value_packer.sv
// value_packer: collects number_blocks samples into one wide vector, slot 0 at the MSBs.
// Optional sticky overflow flag enabled by defining VALUE_PACKER_OVERFLOW_EN.
`default_nettype none

module value_packer #(
    parameter int DATA_WIDTH        = 16,
    parameter int number_blocks     = 8,
    parameter int BITS_FOR_POSITION = 3
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                flush,
    input  logic [DATA_WIDTH-1:0]               in_data,
    input  logic                                in_valid,
    output logic                                in_ready,
    output logic [DATA_WIDTH*number_blocks-1:0] values,
    output logic                                values_valid,
    input  logic                                values_ack,
    output logic [BITS_FOR_POSITION:0]          fill_count,
    output logic                                overflow
);

    localparam int CW = BITS_FOR_POSITION + 1;
    localparam int VW = DATA_WIDTH * number_blocks;

    typedef enum logic [0:0] {
        S_FILL = 1'b0,
        S_FULL = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   fill_count_q, fill_count_d;
    logic [VW-1:0]   values_q, values_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_FILL;
            fill_count_q <= '0;
            values_q     <= '0;
        end else begin
            state_q      <= state_d;
            fill_count_q <= fill_count_d;
            values_q     <= values_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        fill_count_d = fill_count_q;
        values_d     = values_q;
        if (flush) begin
            // Flush wins over both a sample and an ack; held data is left in place.
            state_d      = S_FILL;
            fill_count_d = '0;
        end else begin
            case (state_q)
                S_FILL: begin
                    if (in_valid) begin
                        for (int k = 0; k < number_blocks; k++) begin
                            if (fill_count_q == CW'(k)) begin
                                values_d[DATA_WIDTH*(number_blocks-1-k) +: DATA_WIDTH] = in_data;
                            end
                        end
                        fill_count_d = fill_count_q + CW'(1);
                        if (fill_count_q == CW'(number_blocks - 1)) begin
                            state_d = S_FULL;
                        end
                    end
                end
                S_FULL: begin
                    if (values_ack) begin
                        state_d      = S_FILL;
                        fill_count_d = '0;
                    end
                end
                default: begin
                    state_d      = S_FILL;
                    fill_count_d = '0;
                end
            endcase
        end
    end

    assign in_ready     = (state_q == S_FILL);
    assign values_valid = (state_q == S_FULL);
    assign values       = values_q;
    assign fill_count   = fill_count_q;

`ifdef VALUE_PACKER_OVERFLOW_EN
    logic overflow_q, overflow_d;

    always_comb begin
        overflow_d = overflow_q;
        if (flush) begin
            overflow_d = 1'b0;
        end else if ((state_q == S_FULL) && in_valid) begin
            overflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow_q <= 1'b0;
        end else begin
            overflow_q <= overflow_d;
        end
    end

    assign overflow = overflow_q;
`else
    assign overflow = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_value_packer.sv
// Testbench for value_packer: table-driven vectors plus directed flush/reset/toggle sequences.
`default_nettype none

module tb_value_packer;

    localparam int DW = 16;
    localparam int NB = 8;
    localparam int BP = 3;
    localparam int VW = DW * NB;

`ifdef VALUE_PACKER_OVERFLOW_EN
    localparam logic EXP_OVF = 1'b1;
`else
    localparam logic EXP_OVF = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          flush = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [VW-1:0] values;
    logic          values_valid;
    logic          values_ack = 1'b0;
    logic [BP:0]   fill_count;
    logic          overflow;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    value_packer #(
        .DATA_WIDTH(DW),
        .number_blocks(NB),
        .BITS_FOR_POSITION(BP)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .flush(flush),
        .in_data(in_data),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .values(values),
        .values_valid(values_valid),
        .values_ack(values_ack),
        .fill_count(fill_count),
        .overflow(overflow)
    );

    typedef struct {
        logic          v;
        logic [DW-1:0] d;
        logic          ack;
        logic          fl;
        logic [BP:0]   ef;
        logic          er;
        logic          evv;
        logic          ck_vals;
        logic [VW-1:0] ev;
        logic          ck_ovf;
        logic          eovf;
    } vec_t;

    vec_t vq[$];

    function automatic void add(logic v, logic [DW-1:0] d, logic ack, logic fl,
                                logic [BP:0] ef, logic er, logic evv,
                                logic ck_vals, logic [VW-1:0] ev,
                                logic ck_ovf, logic eovf);
        vec_t e;
        e.v = v; e.d = d; e.ack = ack; e.fl = fl;
        e.ef = ef; e.er = er; e.evv = evv;
        e.ck_vals = ck_vals; e.ev = ev; e.ck_ovf = ck_ovf; e.eovf = eovf;
        vq.push_back(e);
    endfunction

    task automatic chk(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cyc(input logic v, input logic [DW-1:0] d, input logic ack, input logic fl);
        in_valid   = v;
        in_data    = d;
        values_ack = ack;
        flush      = fl;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_state(input string tag, input logic [BP:0] ef, input logic er, input logic evv);
        chk({tag, ".fill_count"}, VW'(fill_count), VW'(ef));
        chk({tag, ".in_ready"}, VW'(in_ready), VW'(er));
        chk({tag, ".values_valid"}, VW'(values_valid), VW'(evv));
    endtask

    localparam logic [VW-1:0] V_SEQ  = 128'h0000_0001_0002_0003_0004_0005_0006_0007;
    localparam logic [VW-1:0] V_SEQ2 = 128'h0010_0011_0012_0013_0014_0015_0016_0017;
    localparam logic [VW-1:0] V_MIX  = 128'h0000_0001_000A_FFE7_0064_0005_0006_0007;
    localparam logic [VW-1:0] V_FL   = 128'hAAAA_0001_0002_0003_0004_0005_0006_0007;

    initial begin
        logic [DW-1:0] mix [NB];
        int            pos_max;
        logic signed [DW-1:0] best;

        // Reset state, checked while rst_n is still low.
        #2;
        chk_state("reset", '0, 1'b1, 1'b0);
        chk("reset.values", values, '0);
        chk("reset.overflow", VW'(overflow), '0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Table: full fill, hold with in_valid, ack, then ack ignored mid-fill.
        for (int i = 0; i < NB; i++) begin
            add(1'b1, DW'(i), 1'b0, 1'b0, (BP+1)'(i+1), (i < NB-1), (i == NB-1),
                (i == NB-1), V_SEQ, 1'b1, 1'b0);
        end
        for (int i = 0; i < 5; i++) begin
            add(1'b1, 16'hDEAD, 1'b0, 1'b0, 4'd8, 1'b0, 1'b1, 1'b1, V_SEQ, 1'b1, EXP_OVF);
        end
        add(1'b0, 16'h0, 1'b1, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, '0, 1'b1, EXP_OVF);
        for (int i = 0; i < 4; i++) begin
            add(1'b1, DW'(16'h10 + i), 1'b0, 1'b0, (BP+1)'(i+1), 1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0);
        end
        add(1'b0, 16'h0, 1'b1, 1'b0, 4'd4, 1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0);
        for (int i = 4; i < NB; i++) begin
            add(1'b1, DW'(16'h10 + i), 1'b0, 1'b0, (BP+1)'(i+1), (i < NB-1), (i == NB-1),
                (i == NB-1), V_SEQ2, 1'b0, 1'b0);
        end
        add(1'b0, 16'h0, 1'b1, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0);

        foreach (vq[i]) begin
            cyc(vq[i].v, vq[i].d, vq[i].ack, vq[i].fl);
            chk_state($sformatf("vec%0d", i), vq[i].ef, vq[i].er, vq[i].evv);
            if (vq[i].ck_vals) chk($sformatf("vec%0d.values", i), values, vq[i].ev);
            if (vq[i].ck_ovf)  chk($sformatf("vec%0d.overflow", i), VW'(overflow), VW'(vq[i].eovf));
        end

        // Samples with in_valid toggling; signed argmax of the result.
        mix = '{16'h0000, 16'h0001, 16'h000A, 16'hFFE7, 16'h0064, 16'h0005, 16'h0006, 16'h0007};
        for (int i = 0; i < NB; i++) begin
            cyc(1'b1, mix[i], 1'b0, 1'b0);
            if (i < NB-1) cyc(1'b0, 16'hBEEF, 1'b0, 1'b0);
        end
        chk_state("mix", 4'd8, 1'b0, 1'b1);
        chk("mix.values", values, V_MIX);
        pos_max = 0;
        best    = $signed(values[VW-1 -: DW]);
        for (int k = 1; k < NB; k++) begin
            if ($signed(values[DW*(NB-1-k) +: DW]) > best) begin
                best    = $signed(values[DW*(NB-1-k) +: DW]);
                pos_max = k;
            end
        end
        chk("mix.pos_max", VW'(pos_max), VW'(4));
        cyc(1'b0, 16'h0, 1'b1, 1'b0);
        chk_state("mix.ack", 4'd0, 1'b1, 1'b0);

        // Flush with a simultaneous sample after 3 accepted.
        for (int i = 0; i < 3; i++) cyc(1'b1, 16'h7777, 1'b0, 1'b0);
        chk_state("pre_flush", 4'd3, 1'b1, 1'b0);
        cyc(1'b1, 16'h5555, 1'b0, 1'b1);
        chk_state("flush", 4'd0, 1'b1, 1'b0);
        chk("flush.overflow", VW'(overflow), '0);
        cyc(1'b1, 16'hAAAA, 1'b0, 1'b0);
        chk_state("after_flush", 4'd1, 1'b1, 1'b0);
        for (int i = 1; i < NB; i++) cyc(1'b1, DW'(i), 1'b0, 1'b0);
        chk_state("flush_fill", 4'd8, 1'b0, 1'b1);
        chk("flush_fill.values", values, V_FL);
        cyc(1'b1, 16'h1234, 1'b0, 1'b0);
        chk("full_in_valid.overflow", VW'(overflow), VW'(EXP_OVF));
        cyc(1'b1, 16'h1234, 1'b0, 1'b1);
        chk_state("flush_full", 4'd0, 1'b1, 1'b0);
        chk("flush_full.values_kept", values, V_FL);
        chk("flush_full.overflow", VW'(overflow), '0);

        // Asynchronous reset pulse between edges with 5 samples held.
        for (int i = 0; i < 5; i++) cyc(1'b1, 16'h4242, 1'b0, 1'b0);
        in_valid = 1'b0;
        chk_state("pre_rst", 4'd5, 1'b1, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk_state("async_rst", 4'd0, 1'b1, 1'b0);
        chk("async_rst.values", values, '0);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < NB; i++) cyc(1'b1, DW'(i), 1'b0, 1'b0);
        chk_state("post_rst", 4'd8, 1'b0, 1'b1);
        chk("post_rst.values", values, V_SEQ);
        cyc(1'b0, 16'h0, 1'b1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/value_packer.md
VALUE_PACKER -- requirements
Module: value_packer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, bit width of one sample.
REQ-002 SHALL have parameter number_blocks, default 8, samples per packed vector.
REQ-003 SHALL have parameter BITS_FOR_POSITION, default 3, log2(number_blocks).
REQ-004 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port flush  input  1  synchronous discard of a partial or complete vector.
REQ-007 SHALL have port in_data  input  DATA_WIDTH  sample, two's-complement, passed through unmodified.
REQ-008 SHALL have port in_valid  input  1  in_data valid this cycle.
REQ-009 SHALL have port in_ready  output  1  packer accepts a sample this cycle.
REQ-010 SHALL have port values  output  DATA_WIDTH*number_blocks  packed vector for the downstream comparator.
REQ-011 SHALL have port values_valid  output  1  values is complete and stable.
REQ-012 SHALL have port values_ack  input  1  consumer has taken values.
REQ-013 SHALL have port fill_count  output  BITS_FOR_POSITION+1  samples held in the current vector, 0..number_blocks.
REQ-014 SHALL have port overflow  output  1  sticky flag for a sample offered while full.

Function
REQ-015 SHALL implement two states: FILL (in_ready=1, values_valid=0) and FULL (in_ready=0, values_valid=1).
REQ-016 Accept: in FILL, in_valid=1 SHALL write in_data to slot k=fill_count and increment fill_count.
REQ-017 Slot k SHALL occupy values[DATA_WIDTH*(number_blocks-k)-1 : DATA_WIDTH*(number_blocks-k-1)]: slot 0 at the MSBs, slot number_blocks-1 at the LSBs.
REQ-018 When the accepted sample is slot number_blocks-1, the FSM SHALL enter FULL on that edge, with fill_count=number_blocks.
REQ-019 values_valid SHALL rise in the cycle after the number_blocks-th accepted sample (latency 1 cycle).
REQ-020 In FULL, values SHALL hold constant, and in_valid SHALL NOT change values or fill_count.
REQ-021 In FULL, values_ack=1 SHALL move the FSM to FILL on that edge, with fill_count=0, so values_valid falls the next cycle.
REQ-022 values_ack SHALL be ignored in FILL.
REQ-023 Minimum period between vectors SHALL be number_blocks+1 cycles, with one bubble cycle for the ack.
REQ-024 Slots not yet rewritten in FILL SHALL retain their old contents; values is meaningful only while values_valid=1.
REQ-025 flush=1 SHALL set fill_count=0 and state FILL on that edge, in any state.
REQ-026 flush SHALL take priority over in_valid and values_ack in the same cycle; the sample is not accepted.
REQ-027 flush SHALL NOT clear values.
REQ-028 fill_count SHALL never exceed number_blocks and SHALL never wrap.

Reset
REQ-029 rst_n=0 SHALL immediately, without a clock edge, force: state FILL, fill_count=0, values=0, values_valid=0, overflow=0.
REQ-030 After reset, in_ready SHALL be 1.
REQ-031 Reset asserted mid-fill or in FULL SHALL discard all held samples; the first sample after release goes to slot 0.

Configuration
REQ-032 Macro VALUE_PACKER_OVERFLOW_EN defined: overflow SHALL set on any edge with state FULL and in_valid=1, stay set, and clear only on rst_n=0 or flush=1.
REQ-033 Macro VALUE_PACKER_OVERFLOW_EN undefined: overflow port SHALL remain present and be tied to 0, with no overflow logic.

Verification
REQ-034 Reset release, then samples 0..7 on 8 consecutive cycles -> values_valid=1 on cycle 9, values=0x0000_0001_0002_0003_0004_0005_0006_0007, fill_count=8, in_ready=0.
REQ-035 Full vector held 5 cycles with in_valid=1, then values_ack=1 -> values unchanged for 5 cycles; overflow=1 with macro, 0 without; next cycle values_valid=0, fill_count=0, in_ready=1.
REQ-036 Samples 0,1,10,-25(0xFFE7),100,5,6,7 with in_valid toggling 1/0 -> values = 0x0000_0001_000A_FFE7_0064_0005_0006_0007; comparator downstream reports pos_max=4.
REQ-037 3 samples accepted, then flush=1 and in_valid=1 same cycle -> fill_count=0, sample dropped, overflow cleared; next sample lands in slot 0.
REQ-038 rst_n pulsed low for 2 ns between edges with 5 samples held -> outputs zero immediately; fill_count=0 without a clock edge.
REQ-039 values_ack=1 while in FILL with fill_count=4 -> no effect; fill continues to 8 normally.
